// File: rtl/flag_branch_ctrl_pkg.sv
// Shared encodings for the flag/branch controller: opcodes, branch condition codes,
// the NOP instruction word and the hazard FSM states.
package flag_branch_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CCC_NE = 3'b000;
  localparam logic [2:0] CCC_EQ = 3'b001;
  localparam logic [2:0] CCC_GT = 3'b010;
  localparam logic [2:0] CCC_LT = 3'b011;
  localparam logic [2:0] CCC_GE = 3'b100;
  localparam logic [2:0] CCC_LE = 3'b101;
  localparam logic [2:0] CCC_OV = 3'b110;
  localparam logic [2:0] CCC_UN = 3'b111;

  localparam logic [15:0] NOP_INSTR = 16'h4000;

  typedef enum logic {IDLE, HAZ} state_t;

  function automatic logic is_flag_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR};
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// EX/ID-side inputs and branch/flag outputs of the flag/branch controller.
interface flag_branch_ctrl_if #(parameter int CNT_W = 16);
  logic [15:0]      ex_instr;
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [15:0]      alu_result;
  logic             alu_overflow;
  logic             id_branch;
  logic [2:0]       id_ccc;
  logic             pipe_hold;
  logic [2:0]       flags;
  logic             branch_stall;
  logic             branch_resolved;
  logic             branch_taken;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output ex_instr, ex_valid, ex_opcode, alu_result, alu_overflow,
           id_branch, id_ccc, pipe_hold,
    input  flags, branch_stall, branch_resolved, branch_taken, taken_count
  );

  modport slave (
    input  ex_instr, ex_valid, ex_opcode, alu_result, alu_overflow,
           id_branch, id_ccc, pipe_hold,
    output flags, branch_stall, branch_resolved, branch_taken, taken_count
  );
endinterface

// File: rtl/flag_branch_ctrl_cond_eval.sv
// Combinational branch condition evaluator: (ccc, {Z,V,N}) -> taken.
// Shared with the fetch-side predictor check.
module flag_cond_eval
  import flag_branch_ctrl_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic [2:0] i_flags,
  output logic       o_taken
);
  logic w_z, w_v, w_n;
  assign {w_z, w_v, w_n} = i_flags;

  always_comb begin
    o_taken = 1'b0;
    case (i_ccc)
      CCC_NE:  o_taken = ~w_z;
      CCC_EQ:  o_taken = w_z;
      CCC_GT:  o_taken = ~w_z & ~w_n;
      CCC_LT:  o_taken = w_n;
      CCC_GE:  o_taken = w_z | ~w_n;
      CCC_LE:  o_taken = w_z | w_n;
      CCC_OV:  o_taken = w_v;
      default: o_taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/flag_branch_ctrl.sv
// Z/V/N flag owner and conditional-branch sequencer; stalls ID one cycle when the
// instruction in EX is about to rewrite the flags the branch depends on.
module flag_branch_ctrl
  import flag_branch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  flag_branch_ctrl_if.slave  bus
);
  state_t           r_state, w_state_nxt;
  logic [2:0]       r_ccc;
  logic             r_z, r_v, r_n;
  logic             r_resolved, r_taken;
  logic [CNT_W-1:0] r_cnt;

  logic       w_ex_fw, w_stall, w_resolve, w_latch, w_eval;
  logic [2:0] w_ccc_sel;

  // NOP words are excluded explicitly: 16'h4000 decodes as SLL by opcode alone.
  assign w_ex_fw = bus.ex_valid && (bus.ex_instr != 16'h0000) &&
                   (bus.ex_instr != NOP_INSTR) && is_flag_op(bus.ex_opcode);

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.id_branch) begin
          if (w_ex_fw) begin
            w_stall = 1'b1;
            if (!bus.pipe_hold) begin
              w_latch     = 1'b1;
              w_state_nxt = HAZ;
            end
          end else if (!bus.pipe_hold) begin
            w_resolve = 1'b1;
          end
        end
      end
      HAZ: begin
        w_stall = 1'b1;
        if (!bus.pipe_hold) begin
          w_resolve   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In HAZ the branch is judged against the latched ccc and the freshly written flags.
  assign w_ccc_sel = (r_state == HAZ) ? r_ccc : bus.id_ccc;

  flag_cond_eval u_eval (
    .i_ccc   (w_ccc_sel),
    .i_flags ({r_z, r_v, r_n}),
    .o_taken (w_eval)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ccc      <= 3'b000;
      r_z        <= 1'b0;
      r_v        <= 1'b0;
      r_n        <= 1'b0;
      r_resolved <= 1'b0;
      r_taken    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_resolved <= w_resolve;
      r_taken    <= w_resolve & w_eval;
      if (w_latch) r_ccc <= bus.id_ccc;
      if (w_ex_fw && !bus.pipe_hold) begin
        r_z <= (bus.alu_result == 16'h0000);
        if (is_arith_op(bus.ex_opcode)) begin
          r_v <= bus.alu_overflow;
          r_n <= bus.alu_result[15];
        end
      end
      if (w_resolve && w_eval && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.flags           = {r_z, r_v, r_n};
  assign bus.branch_stall    = w_stall;
  assign bus.branch_resolved = r_resolved;
  assign bus.branch_taken    = r_taken;
  assign bus.taken_count     = r_cnt;
endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl: vector table plus hand sequences for reset
// mid-hazard and counter saturation.
module tb_flag_branch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_branch_ctrl_if #(.CNT_W(16)) bif ();
  flag_branch_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  typedef struct {
    logic        ev;
    logic [3:0]  op;
    logic [15:0] instr;
    logic [15:0] res;
    logic        ovf;
    logic        br;
    logic [2:0]  ccc;
    logic        hold;
    logic        es;     // stall expected before the edge
    logic [2:0]  ef;     // flags after the edge
    logic        er;
    logic        et;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic ev, logic [3:0] op, logic [15:0] instr, logic [15:0] res,
                              logic ovf, logic br, logic [2:0] ccc, logic hold, logic es,
                              logic [2:0] ef, logic er, logic et, logic [15:0] ec);
    vec_t v;
    v.ev = ev; v.op = op; v.instr = instr; v.res = res; v.ovf = ovf; v.br = br;
    v.ccc = ccc; v.hold = hold; v.es = es; v.ef = ef; v.er = er; v.et = et; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bif.ex_valid     = v.ev;
    bif.ex_opcode    = v.op;
    bif.ex_instr     = v.instr;
    bif.alu_result   = v.res;
    bif.alu_overflow = v.ovf;
    bif.id_branch    = v.br;
    bif.id_ccc       = v.ccc;
    bif.pipe_hold    = v.hold;
  endtask

  initial begin
    vec_t v;
    // ev op    instr     res      ovf br ccc   hold stall flags res tkn cnt
    vecs.push_back(mk(1, 4'h0, 16'h0123, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b100, 0, 0, 0));  // ADD zero
    vecs.push_back(mk(1, 4'h1, 16'h1123, 16'h7FFF, 1, 0, 3'd0, 0, 0, 3'b010, 0, 0, 0));  // SUB ovf
    vecs.push_back(mk(1, 4'h1, 16'h1123, 16'h8000, 0, 0, 3'd0, 0, 0, 3'b001, 0, 0, 0));  // SUB neg
    vecs.push_back(mk(1, 4'h2, 16'h2123, 16'h8000, 1, 0, 3'd0, 0, 0, 3'b001, 0, 0, 0));  // XOR keeps V/N
    vecs.push_back(mk(1, 4'h4, 16'h4000, 16'h0000, 0, 1, 3'd7, 0, 0, 3'b001, 1, 1, 1));  // NOP + UN
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd3, 0, 0, 3'b001, 1, 1, 2));  // LT back-to-back
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd2, 0, 0, 3'b001, 1, 0, 2));  // GT not taken
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b001, 0, 0, 2));  // pulse drops
    vecs.push_back(mk(1, 4'h0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b001, 0, 0, 2));  // 0000 nop
    vecs.push_back(mk(0, 4'h0, 16'h0123, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b001, 0, 0, 2));  // invalid EX
    vecs.push_back(mk(1, 4'h0, 16'h0123, 16'h0000, 0, 0, 3'd0, 1, 0, 3'b001, 0, 0, 2));  // hold blocks flags
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd7, 1, 0, 3'b001, 0, 0, 2));  // hold blocks resolve
    vecs.push_back(mk(1, 4'h0, 16'h0123, 16'h0000, 0, 1, 3'd1, 0, 1, 3'b100, 0, 0, 2));  // hazard cycle 1
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd1, 0, 1, 3'b100, 1, 1, 3));  // hazard cycle 2
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b100, 0, 0, 3));
    vecs.push_back(mk(1, 4'h1, 16'h1123, 16'h1234, 0, 1, 3'd0, 0, 1, 3'b000, 0, 0, 3));  // hazard NE
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd1, 1, 1, 3'b000, 0, 0, 3));  // held in HAZ x3
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd1, 1, 1, 3'b000, 0, 0, 3));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd1, 1, 1, 3'b000, 0, 0, 3));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd1, 0, 1, 3'b000, 1, 1, 4));  // release: latched NE
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b000, 0, 0, 4));
    vecs.push_back(mk(1, 4'h0, 16'h0123, 16'hFFFF, 1, 0, 3'd0, 0, 0, 3'b011, 0, 0, 4));  // ADD neg ovf
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd6, 0, 0, 3'b011, 1, 1, 5));  // OV
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd4, 0, 0, 3'b011, 1, 0, 5));  // GE
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd5, 0, 0, 3'b011, 1, 1, 6));  // LE
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd1, 0, 0, 3'b011, 1, 0, 6));  // EQ
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 0, 1, 3'd0, 0, 0, 3'b011, 1, 1, 7));  // NE
    vecs.push_back(mk(1, 4'h3, 16'h3123, 16'h0000, 0, 1, 3'd7, 0, 0, 3'b011, 1, 1, 8));  // non-flag op

    v = mk(0, 4'h0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 0, 3'b000, 0, 0, 0);
    drive(v);
    #12;
    chk("reset_flags", bif.flags, 3'b000);
    chk("reset_resolved", bif.branch_resolved, 1'b0);
    chk("reset_count", bif.taken_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), bif.branch_stall, vecs[i].es);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flags", i), bif.flags, vecs[i].ef);
      chk($sformatf("v%0d_resolved", i), bif.branch_resolved, vecs[i].er);
      chk($sformatf("v%0d_taken", i), bif.branch_taken, vecs[i].et);
      chk($sformatf("v%0d_count", i), bif.taken_count, vecs[i].ec);
    end

    // Async reset while sitting in HAZ.
    @(negedge clk);
    drive(mk(1, 4'h0, 16'h0123, 16'h0000, 0, 1, 3'd1, 0, 0, 3'b000, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("haz_entry_flags", bif.flags, 3'b100);
    @(negedge clk);
    bif.ex_valid = 1'b0;
    #1;
    chk("haz_stall", bif.branch_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_haz_flags", bif.flags, 3'b000);
    chk("rst_haz_stall", bif.branch_stall, 1'b0);
    chk("rst_haz_resolved", bif.branch_resolved, 1'b0);
    chk("rst_haz_count", bif.taken_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: NOP 4000 in EX with UN branch every cycle.
    drive(mk(1, 4'h4, 16'h4000, 16'h0000, 0, 1, 3'd7, 0, 0, 3'b000, 0, 0, 0));
    #1;
    chk("sat_stall", bif.branch_stall, 1'b0);
    for (int i = 1; i <= 65537; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        chk("sat_first_resolved", bif.branch_resolved, 1'b1);
        chk("sat_first_taken", bif.branch_taken, 1'b1);
      end
      if (i == 65534) chk("sat_fffe", bif.taken_count, 16'hFFFE);
      if (i == 65535) chk("sat_ffff", bif.taken_count, 16'hFFFF);
    end
    chk("sat_hold_ffff", bif.taken_count, 16'hFFFF);
    chk("sat_flags", bif.flags, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
